// File: rtl/score_pkg.sv
// Shared types and default constants for the score display controller.
// The converter FSM states and BCD geometry live here so the top and step agree.
package score_pkg;

    localparam int SCORE_W_DEFAULT    = 8;
    localparam int WRAP_VALUE_DEFAULT = 251;
    localparam int BCD_DIGITS_DEFAULT = 3;
    localparam int NIBBLE_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add-3 correction on every nibble >= 5, then
// shift the BCD accumulator left by one with the next binary bit entering at the LSB.
module bcd_dd_step
    import score_pkg::*;
#(
    parameter int BCD_DIGITS = BCD_DIGITS_DEFAULT
) (
    input  logic [BCD_DIGITS*NIBBLE_W-1:0] bcd,
    input  logic                           msb,
    output logic [BCD_DIGITS*NIBBLE_W-1:0] shifted
);

    localparam int BCD_W = BCD_DIGITS * NIBBLE_W;

    logic [BCD_W-1:0] adjusted;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        adjusted = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*NIBBLE_W +: NIBBLE_W] >= 4'd5) begin
                adjusted[i*NIBBLE_W +: NIBBLE_W] = bcd[i*NIBBLE_W +: NIBBLE_W] + 4'd3;
            end
        end
        shifted = {adjusted[BCD_W-2:0], msb};
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score / high-score registers plus a sequential double-dabble converter that
// refreshes the BCD display only when a conversion completes.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int SCORE_W    = SCORE_W_DEFAULT,
    parameter int WRAP_VALUE = WRAP_VALUE_DEFAULT,
    parameter int BCD_DIGITS = BCD_DIGITS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           score_inc,
    input  logic                           score_clr,
    input  logic                           show_high,
    output logic [BCD_DIGITS*NIBBLE_W-1:0] bcd_out,
    output logic [BCD_DIGITS-1:0]          digit_blank,
    output logic                           busy,
    output logic                           valid,
    output logic                           new_high,
    output logic [SCORE_W-1:0]             score
);

    localparam int                 BCD_W      = BCD_DIGITS * NIBBLE_W;
    localparam int                 CNT_W      = $clog2(SCORE_W + 1);
    localparam logic [SCORE_W-1:0] LAST_SCORE = SCORE_W'(WRAP_VALUE - 1);
    localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(SCORE_W - 1);

    // Leading-zero blanking: a digit blanks only if it and every digit above it are zero.
    function automatic logic [BCD_DIGITS-1:0] blank_flags(input logic [BCD_W-1:0] bcd);
        logic zero_above;
        zero_above  = 1'b1;
        blank_flags = '0;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            zero_above     = zero_above && (bcd[i*NIBBLE_W +: NIBBLE_W] == '0);
            blank_flags[i] = zero_above;
        end
    endfunction

    logic [SCORE_W-1:0] high;
    logic [SCORE_W-1:0] score_d;
    logic               show_high_q;
    logic               score_chg;
    logic               high_chg;
    logic               set_req;

    state_t             state;
    logic               dirty;
    logic [SCORE_W-1:0] src;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        score_d = score;
        if (score_clr) begin
            score_d = '0;
        end else if (score_inc) begin
            score_d = (score == LAST_SCORE) ? '0 : score + 1'b1;
        end
    end

    assign score_chg = (score_d != score);
    assign high_chg  = (score > high);
    assign set_req   = score_chg || high_chg || (show_high != show_high_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score       <= '0;
            high        <= '0;
            new_high    <= 1'b0;
            show_high_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            score       <= score_d;
            show_high_q <= show_high;
            if (high_chg) begin
                high <= score;
            end
            if (score_clr) begin
                new_high <= 1'b0;
            end else if (high_chg) begin
                new_high <= 1'b1;
            end
        end
    end

    bcd_dd_step #(
        .BCD_DIGITS(BCD_DIGITS)
    ) u_step (
        .bcd    (acc),
        .msb    (src[SCORE_W-1]),
        .shifted(acc_next)
    );

    // Converter FSM; a new change request in the LOAD-entry cycle keeps dirty set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            dirty       <= 1'b0;
            src         <= '0;
            acc         <= '0;
            cnt         <= '0;
            bcd_out     <= '0;
            digit_blank <= blank_flags('0);
            busy        <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (set_req) begin
                dirty <= 1'b1;
            end else if (state == IDLE && dirty) begin
                dirty <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (dirty) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    src   <= show_high ? high : score;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    acc <= acc_next;
                    src <= src << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_SHIFT) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end
                end
                DONE: begin
                    bcd_out     <= acc;
                    digit_blank <= blank_flags(acc);
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
